// File: rtl/can_mem_pkg.sv
// ---------------------------------------------------------------------------
// can_mem_pkg
// Shared definitions for the CAN frame buffer RAM controller.
//   - Default RAM data/address widths and the resulting RAM depth.
//   - FSM state encoding for can_ram_ctrl. Plain localparam constants keep
//     the encoding visible to older tools and waveform viewers.
// ---------------------------------------------------------------------------
package can_mem_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int RAM_DEPTH  = 1 << ADDR_W_DEF;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_WR_ACCEPT = 3'd1;
    localparam logic [STATE_W-1:0] ST_WR_STROBE = 3'd2;
    localparam logic [STATE_W-1:0] ST_RD_ISSUE  = 3'd3;
    localparam logic [STATE_W-1:0] ST_RD_WAIT   = 3'd4;
    localparam logic [STATE_W-1:0] ST_RD_HOLD   = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE      = 3'd6;

endpackage

// File: rtl/can_ram_ctrl.sv
// ---------------------------------------------------------------------------
// can_ram_ctrl
// Bus initiator for the CAN frame buffer RAM. Turns write/read burst
// requests from the frame engine into single-byte RAM cycles and streams
// the bytes with valid/ready handshakes.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   reqValid/reqReady            burst request handshake
//   reqWrite, reqAddr, reqLen    burst direction, start address, byte count
//   wrData/wrValid/wrReady       write byte stream (frame engine -> RAM)
//   rdData/rdValid/rdReady       read byte stream (RAM -> frame engine)
//   done                         one-cycle pulse when a burst completes
//   addr, chipSel, wriEn, outEn  registered RAM control pins
//   data                         shared RAM data bus, driven only on writes
// ---------------------------------------------------------------------------
module can_ram_ctrl
    import can_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [LEN_W-1:0]  reqLen,

    input  logic [DATA_W-1:0] wrData,
    input  logic              wrValid,
    output logic              wrReady,

    output logic [DATA_W-1:0] rdData,
    output logic              rdValid,
    input  logic              rdReady,

    output logic              done,

    output logic [ADDR_W-1:0] addr,
    output logic              chipSel,
    output logic              wriEn,
    output logic              outEn,
    inout  logic [DATA_W-1:0] data
);

    // Index of the RD_WAIT cycle on which the RAM data is valid.
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    logic [STATE_W-1:0] state;
    logic [ADDR_W-1:0]  curAddr;
    logic [LEN_W-1:0]   count;
    logic [DATA_W-1:0]  wrLatch;
    logic [1:0]         latCnt;

    // Burst direction is implied by which half of the FSM is active, so no
    // separate direction flop is kept.

    // Handshake outputs decode directly from the registered state.
    assign reqReady = (state == ST_IDLE);
    assign wrReady  = (state == ST_WR_ACCEPT);
    assign rdValid  = (state == ST_RD_HOLD);
    assign done     = (state == ST_DONE);

    // The bus is released whenever no write strobe is active, which also
    // guarantees it is never driven while outEn is high.
    assign data = wriEn ? wrLatch : 'z;

    always_ff @(posedge clk) begin
        // NOTE: every flop here uses <= so all registers update from the
        // values present before the edge; a blocking = would let later
        // statements see half-updated state.
        if (rst) begin
            state   <= ST_IDLE;
            curAddr <= '0;
            count   <= '0;
            wrLatch <= '0;
            rdData  <= '0;
            latCnt  <= '0;
            addr    <= '0;
            chipSel <= 1'b0;
            wriEn   <= 1'b0;
            outEn   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (reqValid) begin
                        curAddr <= reqAddr;
                        count   <= reqLen;
                        if (reqLen == '0) begin
                            state <= ST_DONE;
                        end else if (reqWrite) begin
                            state <= ST_WR_ACCEPT;
                        end else begin
                            // Present the first read address right away.
                            state   <= ST_RD_ISSUE;
                            addr    <= reqAddr;
                            chipSel <= 1'b1;
                            outEn   <= 1'b1;
                            latCnt  <= '0;
                        end
                    end
                end

                ST_WR_ACCEPT: begin
                    if (wrValid) begin
                        wrLatch <= wrData;
                        addr    <= curAddr;
                        chipSel <= 1'b1;
                        wriEn   <= 1'b1;
                        state   <= ST_WR_STROBE;
                    end
                end

                ST_WR_STROBE: begin
                    // RAM captures the byte at the end of this single cycle.
                    chipSel <= 1'b0;
                    wriEn   <= 1'b0;
                    curAddr <= curAddr + 1'b1;
                    count   <= count - LEN_W'(1);
                    state   <= (count == LEN_W'(1)) ? ST_DONE : ST_WR_ACCEPT;
                end

                ST_RD_ISSUE: begin
                    if (RD_LAT == 1) begin
                        rdData  <= data;
                        chipSel <= 1'b0;
                        outEn   <= 1'b0;
                        state   <= ST_RD_HOLD;
                    end else begin
                        latCnt <= 2'd1;
                        state  <= ST_RD_WAIT;
                    end
                end

                ST_RD_WAIT: begin
                    if (latCnt == LAT_LAST) begin
                        rdData  <= data;
                        chipSel <= 1'b0;
                        outEn   <= 1'b0;
                        state   <= ST_RD_HOLD;
                    end else begin
                        latCnt <= latCnt + 2'd1;
                    end
                end

                ST_RD_HOLD: begin
                    if (rdReady) begin
                        curAddr <= curAddr + 1'b1;
                        count   <= count - LEN_W'(1);
                        if (count == LEN_W'(1)) begin
                            state <= ST_DONE;
                        end else begin
                            state   <= ST_RD_ISSUE;
                            addr    <= curAddr + 1'b1;
                            chipSel <= 1'b1;
                            outEn   <= 1'b1;
                            latCnt  <= '0;
                        end
                    end
                end

                ST_DONE: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state   <= ST_IDLE;
                    chipSel <= 1'b0;
                    wriEn   <= 1'b0;
                    outEn   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_can_ram_ctrl
// Directed bench for can_ram_ctrl with a behavioural RAM on the shared bus.
// Expected byte values come from a bench-side copy of what was written.
// ---------------------------------------------------------------------------
module tb_can_ram_ctrl;

    logic       clk;
    logic       rst;
    logic       reqValid;
    logic       reqReady;
    logic       reqWrite;
    logic [7:0] reqAddr;
    logic [3:0] reqLen;
    logic [7:0] wrData;
    logic       wrValid;
    logic       wrReady;
    logic [7:0] rdData;
    logic       rdValid;
    logic       rdReady;
    logic       done;
    logic [7:0] addr;
    logic       chipSel;
    logic       wriEn;
    logic       outEn;
    wire  [7:0] data;

    can_ram_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .reqValid (reqValid),
        .reqReady (reqReady),
        .reqWrite (reqWrite),
        .reqAddr  (reqAddr),
        .reqLen   (reqLen),
        .wrData   (wrData),
        .wrValid  (wrValid),
        .wrReady  (wrReady),
        .rdData   (rdData),
        .rdValid  (rdValid),
        .rdReady  (rdReady),
        .done     (done),
        .addr     (addr),
        .chipSel  (chipSel),
        .wriEn    (wriEn),
        .outEn    (outEn),
        .data     (data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: writes on the clock edge ending a strobe cycle,
    // drives the bus combinationally while selected for read (RD_LAT = 1).
    logic [7:0] mem   [256];
    logic [7:0] model [256];
    logic [7:0] wbuf  [16];

    always @(posedge clk) begin
        if (chipSel && wriEn) mem[addr] <= data;
    end
    assign data = (chipSel && outEn) ? mem[addr] : 'z;

    int total = 0;
    int bad   = 0;
    int overlapCnt = 0;
    int doneCnt    = 0;
    int csCnt      = 0;

    always @(posedge clk) begin
        if (wriEn && outEn) overlapCnt++;
        if (done) doneCnt++;
        if (chipSel) csCnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write burst of wbuf[0..len-1] starting at a, one byte per two cycles.
    task automatic writeBurst(input logic [7:0] a, input int len);
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = a; reqLen = 4'(len);
        tick();
        reqValid = 1'b0;
        for (int i = 0; i < len; i++) begin
            check("wr_ready", 32'(wrReady), 32'h1);
            wrValid = 1'b1;
            wrData  = wbuf[i];
            tick();
            wrValid = 1'b0;
            check("wr_strobe", 32'(wriEn), 32'h1);
            check("wr_cs", 32'(chipSel), 32'h1);
            check("wr_oe", 32'(outEn), 32'h0);
            check("wr_addr", 32'(addr), 32'(8'(a + 8'(i))));
            model[8'(a + 8'(i))] = wbuf[i];
            tick();
            check("wr_strobe_end", 32'(wriEn), 32'h0);
        end
        check("wr_done", 32'(done), 32'h1);
        tick();
        check("wr_done_end", 32'(done), 32'h0);
        check("wr_idle", 32'(reqReady), 32'h1);
    endtask

    // Read burst with rdReady held high; bytes compared to the model.
    task automatic readBurst(input logic [7:0] a, input int len);
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = a; reqLen = 4'(len);
        rdReady = 1'b1;
        tick();
        reqValid = 1'b0;
        for (int i = 0; i < len; i++) begin
            check("rd_issue_cs", 32'(chipSel), 32'h1);
            check("rd_issue_oe", 32'(outEn), 32'h1);
            check("rd_issue_we", 32'(wriEn), 32'h0);
            check("rd_addr", 32'(addr), 32'(8'(a + 8'(i))));
            tick();
            check("rd_valid", 32'(rdValid), 32'h1);
            check("rd_data", 32'(rdData), 32'(model[8'(a + 8'(i))]));
            check("rd_hold_cs", 32'(chipSel), 32'h0);
            tick();
        end
        check("rd_done", 32'(done), 32'h1);
        tick();
        check("rd_done_end", 32'(done), 32'h0);
    endtask

    int doneBefore;
    int csBefore;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 8'h00;
            model[i] = 8'h00;
        end
        rst = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqAddr = 8'h00;
        reqLen = 4'h0; wrData = 8'h00; wrValid = 1'b0; rdReady = 1'b0;
        tick();
        tick();

        // Reset state.
        check("rst_reqReady", 32'(reqReady), 32'h1);
        check("rst_wrReady", 32'(wrReady), 32'h0);
        check("rst_rdValid", 32'(rdValid), 32'h0);
        check("rst_rdData", 32'(rdData), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_addr", 32'(addr), 32'h0);
        check("rst_cs", 32'(chipSel), 32'h0);
        check("rst_we", 32'(wriEn), 32'h0);
        check("rst_oe", 32'(outEn), 32'h0);
        rst = 1'b0;
        tick();
        doneCnt = 0;

        // Plain write burst and read-back.
        wbuf[0] = 8'hA1; wbuf[1] = 8'hA2; wbuf[2] = 8'hA3;
        writeBurst(8'h10, 3);
        check("mem_10", 32'(mem[8'h10]), 32'hA1);
        check("mem_11", 32'(mem[8'h11]), 32'hA2);
        check("mem_12", 32'(mem[8'h12]), 32'hA3);
        check("done_once", 32'(doneCnt), 32'h1);
        readBurst(8'h10, 3);

        // Address wrap across 0xFF.
        wbuf[0] = 8'h11; wbuf[1] = 8'h12; wbuf[2] = 8'h13; wbuf[3] = 8'h14;
        writeBurst(8'hFE, 4);
        check("mem_ff", 32'(mem[8'hFF]), 32'h12);
        check("mem_00", 32'(mem[8'h00]), 32'h13);
        check("mem_01", 32'(mem[8'h01]), 32'h14);
        readBurst(8'hFE, 4);

        // Read backpressure: byte held while rdReady is low.
        reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 8'h10; reqLen = 4'd2;
        rdReady = 1'b0;
        tick();
        reqValid = 1'b0;
        check("bp_issue_cs", 32'(chipSel), 32'h1);
        tick();
        check("bp_valid", 32'(rdValid), 32'h1);
        check("bp_data", 32'(rdData), 32'hA1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", 32'(rdValid), 32'h1);
            check("bp_hold_data", 32'(rdData), 32'hA1);
            check("bp_hold_cs", 32'(chipSel), 32'h0);
        end
        rdReady = 1'b1;
        tick();
        check("bp_next_cs", 32'(chipSel), 32'h1);
        check("bp_next_addr", 32'(addr), 32'h11);
        check("bp_next_valid", 32'(rdValid), 32'h0);
        tick();
        check("bp_data2", 32'(rdData), 32'hA2);
        tick();
        check("bp_done", 32'(done), 32'h1);
        tick();

        // Write gaps: no strobe until a byte arrives.
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 8'h30; reqLen = 4'd1;
        tick();
        reqValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("gap_we", 32'(wriEn), 32'h0);
            check("gap_ready", 32'(wrReady), 32'h1);
            tick();
        end
        wrValid = 1'b1; wrData = 8'h5C;
        tick();
        wrValid = 1'b0;
        check("gap_strobe", 32'(wriEn), 32'h1);
        check("gap_addr", 32'(addr), 32'h30);
        tick();
        check("gap_done", 32'(done), 32'h1);
        tick();
        check("mem_30", 32'(mem[8'h30]), 32'h5C);

        // Zero-length request: done next cycle, no chip select.
        csBefore = csCnt;
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 8'h50; reqLen = 4'd0;
        tick();
        reqValid = 1'b0;
        check("len0_done", 32'(done), 32'h1);
        tick();
        check("len0_done_end", 32'(done), 32'h0);
        check("len0_no_cs", 32'(csCnt), 32'(csBefore));

        // Reset in the middle of a 4-byte write after the first byte.
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 8'h40; reqLen = 4'd4;
        tick();
        reqValid = 1'b0;
        wrValid = 1'b1; wrData = 8'h77;
        tick();
        wrValid = 1'b0;
        tick();
        check("mid_wr_ready", 32'(wrReady), 32'h1);
        doneBefore = doneCnt;
        rst = 1'b1; wrValid = 1'b1; wrData = 8'h88;
        tick();
        check("mid_rst_reqReady", 32'(reqReady), 32'h1);
        check("mid_rst_wrReady", 32'(wrReady), 32'h0);
        check("mid_rst_we", 32'(wriEn), 32'h0);
        check("mid_rst_cs", 32'(chipSel), 32'h0);
        check("mid_rst_addr", 32'(addr), 32'h0);
        check("mid_rst_done", 32'(done), 32'h0);
        rst = 1'b0; wrValid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("mid_rst_no_done", 32'(doneCnt), 32'(doneBefore));
        check("mem_40", 32'(mem[8'h40]), 32'h77);
        check("mem_41", 32'(mem[8'h41]), 32'h00);
        wbuf[0] = 8'h99;
        writeBurst(8'h40, 1);
        readBurst(8'h40, 1);

        check("no_we_oe_overlap", 32'(overlapCnt), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
